// File: rtl/frac_scan_ctrl_if.sv
// Bus between the pixel-sweep controller, its host, the iteration engine and the frame buffer.
// The master modport is the controller's view; slave is the surrounding system's view.
interface frac_scan_ctrl_if #(
   parameter int unsigned W  = 32,
   parameter int unsigned AW = 19,
   parameter int unsigned DW = 8
);
   logic          start;
   logic          abort;
   logic [W-1:0]  x0;
   logic [W-1:0]  y0;
   logic [W-1:0]  step;
   logic [15:0]   max_it;
   logic          frac_ready;
   logic          frac_done_tick;
   logic [15:0]   iter;
   logic          frac_start;
   logic [W-1:0]  cx;
   logic [W-1:0]  cy;
   logic [15:0]   max_it_o;
   logic          wr_en;
   logic [AW-1:0] wr_addr;
   logic [DW-1:0] wr_data;
   logic          ready;
   logic          done_tick;

   modport master (
      input  start, abort, x0, y0, step, max_it, frac_ready, frac_done_tick, iter,
      output frac_start, cx, cy, max_it_o, wr_en, wr_addr, wr_data, ready, done_tick
   );

   modport slave (
      output start, abort, x0, y0, step, max_it, frac_ready, frac_done_tick, iter,
      input  frac_start, cx, cy, max_it_o, wr_en, wr_addr, wr_data, ready, done_tick
   );
endinterface

// File: rtl/frac_scan_ctrl.sv
// Raster sweep of an H_RES x V_RES grid: issues one (cx,cy) per pixel to the Mandelbrot
// engine and writes the returned iteration count, mapped to a colour, to the frame buffer.
module frac_scan_ctrl #(
   parameter int unsigned W     = 32,
   parameter int unsigned M     = 4,
   parameter int unsigned H_RES = 640,
   parameter int unsigned V_RES = 480,
   parameter int unsigned AW    = 19,
   parameter int unsigned DW    = 8
) (
   input  logic clk,
   input  logic reset,
   frac_scan_ctrl_if.master bus
);
   // Qm.f needs at least one fraction bit, and the whole frame must be addressable.
   if (M >= W || (64'd1 << AW) < 64'(H_RES) * 64'(V_RES)) begin : g_bad_params
      $error("frac_scan_ctrl: inconsistent W/M/AW/H_RES/V_RES");
   end

   localparam int unsigned CW   = (H_RES > 1) ? $clog2(H_RES) : 1;
   localparam int unsigned RW   = (V_RES > 1) ? $clog2(V_RES) : 1;
   localparam int unsigned DMAX = (1 << DW) - 1;

   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_ISSUE = 3'd1;
   localparam logic [2:0] S_WAIT  = 3'd2;
   localparam logic [2:0] S_WRITE = 3'd3;
   localparam logic [2:0] S_ADV   = 3'd4;

   logic [2:0]    state;
   logic [CW-1:0] col;
   logic [RW-1:0] row;
   logic [W-1:0]  x0_q;
   logic [W-1:0]  step_q;
   logic [W-1:0]  cx_q;
   logic [W-1:0]  cy_q;
   logic [15:0]   max_it_q;
   logic          frac_start_q;
   logic          wr_en_q;
   logic          done_q;
   logic          abort_flag;
   logic [AW-1:0] wr_addr_q;
   logic [DW-1:0] wr_data_q;
   logic [AW-1:0] addr_calc;
   logic [DW-1:0] color;
   logic          last_col;
   logic          last_pix;

   assign last_col  = (col == CW'(H_RES - 1));
   assign last_pix  = last_col && (row == RW'(V_RES - 1));
   assign addr_calc = AW'(row) * AW'(H_RES) + AW'(col);

   always_comb begin
      color = '0;
      if (bus.iter >= max_it_q) begin
         color = '0;
      end else if (32'(bus.iter) > DMAX) begin
         color = '1;
      end else begin
         color = DW'(bus.iter);
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state        <= S_IDLE;
         col          <= '0;
         row          <= '0;
         x0_q         <= '0;
         step_q       <= '0;
         cx_q         <= '0;
         cy_q         <= '0;
         max_it_q     <= '0;
         frac_start_q <= 1'b0;
         wr_en_q      <= 1'b0;
         done_q       <= 1'b0;
         abort_flag   <= 1'b0;
         wr_addr_q    <= '0;
         wr_data_q    <= '0;
      end else begin
         frac_start_q <= 1'b0;
         wr_en_q      <= 1'b0;
         done_q       <= 1'b0;
         if (state != S_IDLE && bus.abort) abort_flag <= 1'b1;

         case (state)
            S_IDLE: begin
               abort_flag <= 1'b0;
               if (bus.start) begin
                  x0_q     <= bus.x0;
                  step_q   <= bus.step;
                  max_it_q <= bus.max_it;
                  cx_q     <= bus.x0;
                  cy_q     <= bus.y0;
                  col      <= '0;
                  row      <= '0;
                  state    <= S_ISSUE;
               end
            end
            S_ISSUE: begin
               if (bus.frac_ready) begin
                  frac_start_q <= 1'b1;
                  state        <= S_WAIT;
               end
            end
            S_WAIT: begin
               // The colour is registered straight from iter, so the strobe lands in WRITE.
               if (bus.frac_done_tick) begin
                  wr_en_q   <= 1'b1;
                  wr_addr_q <= addr_calc;
                  wr_data_q <= color;
                  state     <= S_WRITE;
               end
            end
            S_WRITE: begin
               state <= S_ADV;
            end
            S_ADV: begin
               if (last_col) begin
                  col  <= '0;
                  cx_q <= x0_q;
                  row  <= row + RW'(1);
                  cy_q <= cy_q - step_q;
               end else begin
                  col  <= col + CW'(1);
                  cx_q <= cx_q + step_q;
               end
               if (last_pix) begin
                  done_q     <= 1'b1;
                  abort_flag <= 1'b0;
                  state      <= S_IDLE;
               end else if (abort_flag || bus.abort) begin
                  abort_flag <= 1'b0;
                  state      <= S_IDLE;
               end else begin
                  state <= S_ISSUE;
               end
            end
            default: begin
               state <= S_IDLE;
            end
         endcase
      end
   end

   assign bus.frac_start = frac_start_q;
   assign bus.cx         = cx_q;
   assign bus.cy         = cy_q;
   assign bus.max_it_o   = max_it_q;
   assign bus.wr_en      = wr_en_q;
   assign bus.wr_addr    = wr_addr_q;
   assign bus.wr_data    = wr_data_q;
   assign bus.ready      = (state == S_IDLE);
   assign bus.done_tick  = done_q;
endmodule

// File: tb/tb_frac_scan_ctrl.sv
// Directed bench for frac_scan_ctrl on a 4x3 grid with a fixed-latency engine model.
module tb_frac_scan_ctrl;
   localparam int unsigned W  = 32;
   localparam int unsigned AW = 8;
   localparam int unsigned DW = 8;

   logic clk;
   logic reset;

   frac_scan_ctrl_if #(.W(W), .AW(AW), .DW(DW)) bus ();

   frac_scan_ctrl #(
      .W(W), .M(4), .H_RES(4), .V_RES(3), .AW(AW), .DW(DW)
   ) dut (
      .clk(clk),
      .reset(reset),
      .bus(bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] x0, y0, step;
      logic [15:0] max_it, iter;
      int unsigned lat;
      logic [7:0]  exp_data;
      logic [31:0] cx5, cy5, cx11, cy11;
   } vec_t;

   vec_t vecs[6];

   int unsigned nvec = 0;
   int unsigned nfail = 0;

   // engine model controls
   logic        ready_en;
   logic        stray_req;
   logic [15:0] eng_iter;
   int unsigned eng_lat;
   logic        busy;
   int unsigned cnt;

   // monitor state
   int unsigned nstart, nwr, ndone, done_at_wr;
   logic [31:0] hold_cx, hold_cy;
   logic [AW-1:0] log_addr[$];
   logic [DW-1:0] log_data[$];
   logic [31:0]   log_cx[$];
   logic [31:0]   log_cy[$];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      nvec++;
      if (act !== exp) begin
         nfail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   initial begin
      bus.frac_ready     = 1'b0;
      bus.frac_done_tick = 1'b0;
      bus.iter           = '0;
      busy = 1'b0;
      cnt  = 0;
      forever begin
         @(posedge clk);
         #1;
         bus.frac_done_tick = 1'b0;
         if (!reset) begin
            busy = 1'b0;
         end else if (busy) begin
            if (cnt == 0) begin
               bus.frac_done_tick = 1'b1;
               bus.iter = eng_iter;
               busy = 1'b0;
            end else begin
               cnt--;
            end
         end else if (bus.frac_start) begin
            busy = 1'b1;
            cnt  = eng_lat;
         end else if (stray_req) begin
            bus.frac_done_tick = 1'b1;
            bus.iter = eng_iter;
            stray_req = 1'b0;
         end
         bus.frac_ready = ready_en && !busy;
      end
   end

   always @(posedge clk) begin
      #2;
      if (bus.frac_start) begin
         nstart++;
         hold_cx = bus.cx;
         hold_cy = bus.cy;
      end
      if (bus.wr_en) begin
         log_addr.push_back(bus.wr_addr);
         log_data.push_back(bus.wr_data);
         log_cx.push_back(bus.cx);
         log_cy.push_back(bus.cy);
         nwr++;
         check("cx_hold", 64'(bus.cx), 64'(hold_cx));
         check("cy_hold", 64'(bus.cy), 64'(hold_cy));
      end
      if (bus.done_tick) begin
         ndone++;
         done_at_wr = nwr;
      end
   end

   task automatic clear_logs();
      nstart = 0;
      nwr = 0;
      ndone = 0;
      done_at_wr = 0;
      log_addr.delete();
      log_data.delete();
      log_cx.delete();
      log_cy.delete();
   endtask

   task automatic load_cfg(input vec_t v);
      bus.x0     = v.x0;
      bus.y0     = v.y0;
      bus.step   = v.step;
      bus.max_it = v.max_it;
      eng_iter   = v.iter;
      eng_lat    = v.lat;
   endtask

   task automatic wait_done(input string name, input int unsigned target);
      int unsigned t = 0;
      while (ndone < target && t < 3000) begin
         @(negedge clk);
         t++;
      end
      if (ndone < target) check(name, 64'(ndone), 64'(target));
   endtask

   task automatic wait_start(input string name, input int unsigned target);
      int unsigned t = 0;
      while (nstart < target && t < 1000) begin
         @(negedge clk);
         t++;
      end
      if (nstart < target) check(name, 64'(nstart), 64'(target));
   endtask

   task automatic wait_ready(input string name);
      int unsigned t = 0;
      while (bus.ready !== 1'b1 && t < 1000) begin
         @(negedge clk);
         t++;
      end
      if (bus.ready !== 1'b1) check(name, 64'(bus.ready), 64'd1);
   endtask

   task automatic run_frame(input vec_t v);
      clear_logs();
      load_cfg(v);
      bus.start = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
      wait_done("frame_timeout", 1);
      repeat (5) @(negedge clk);
      check("n_writes", 64'(nwr), 64'd12);
      check("n_starts", 64'(nstart), 64'd12);
      check("n_done", 64'(ndone), 64'd1);
      check("done_after_last", 64'(done_at_wr), 64'd12);
      check("max_it_o", 64'(bus.max_it_o), 64'(v.max_it));
      check("ready_after", 64'(bus.ready), 64'd1);
      for (int i = 0; i < 12 && i < int'(nwr); i++) begin
         check("wr_addr", 64'(log_addr[i]), 64'(i));
         check("wr_data", 64'(log_data[i]), 64'(v.exp_data));
      end
      if (nwr == 12) begin
         check("cx_pix5", 64'(log_cx[5]), 64'(v.cx5));
         check("cy_pix5", 64'(log_cy[5]), 64'(v.cy5));
         check("cx_pix11", 64'(log_cx[11]), 64'(v.cx11));
         check("cy_pix11", 64'(log_cy[11]), 64'(v.cy11));
      end
   endtask

   task automatic check_reset_state(input string tag);
      check({tag, "_ready"}, 64'(bus.ready), 64'd1);
      check({tag, "_frac_start"}, 64'(bus.frac_start), 64'd0);
      check({tag, "_wr_en"}, 64'(bus.wr_en), 64'd0);
      check({tag, "_done_tick"}, 64'(bus.done_tick), 64'd0);
      check({tag, "_cx"}, 64'(bus.cx), 64'd0);
      check({tag, "_cy"}, 64'(bus.cy), 64'd0);
      check({tag, "_wr_addr"}, 64'(bus.wr_addr), 64'd0);
      check({tag, "_wr_data"}, 64'(bus.wr_data), 64'd0);
      check({tag, "_max_it_o"}, 64'(bus.max_it_o), 64'd0);
   endtask

   initial begin
      //           x0            y0            step          max   iter  lat data   cx5           cy5           cx11          cy11
      vecs[0] = '{32'hE0000000, 32'h10000000, 32'h04000000, 16'd100, 16'd7,   3, 8'h07, 32'hE4000000, 32'h0C000000, 32'hEC000000, 32'h08000000};
      vecs[1] = '{32'h00000000, 32'h00000000, 32'h00000001, 16'd64,  16'd64,  2, 8'h00, 32'h00000001, 32'hFFFFFFFF, 32'h00000003, 32'hFFFFFFFE};
      vecs[2] = '{32'h7FFFFFFF, 32'h80000000, 32'h40000000, 16'd500, 16'd300, 4, 8'hFF, 32'hBFFFFFFF, 32'h40000000, 32'h3FFFFFFF, 32'h00000000};
      vecs[3] = '{32'h12345678, 32'h00000000, 32'h00000000, 16'd256, 16'd255, 1, 8'hFF, 32'h12345678, 32'h00000000, 32'h12345678, 32'h00000000};
      vecs[4] = '{32'h00000001, 32'h00000005, 32'h00000002, 16'd0,   16'd0,   0, 8'h00, 32'h00000003, 32'h00000003, 32'h00000007, 32'h00000001};
      vecs[5] = '{32'h00000000, 32'h00000000, 32'hFFFFFFFF, 16'd64,  16'd63,  5, 8'h3F, 32'hFFFFFFFF, 32'h00000001, 32'hFFFFFFFD, 32'h00000002};

      reset = 1'b0;
      bus.start = 1'b0;
      bus.abort = 1'b0;
      bus.x0 = '0;
      bus.y0 = '0;
      bus.step = '0;
      bus.max_it = '0;
      ready_en = 1'b1;
      stray_req = 1'b0;
      eng_iter = '0;
      eng_lat = 3;
      clear_logs();
      hold_cx = '0;
      hold_cy = '0;
      repeat (3) @(negedge clk);
      check_reset_state("rst");
      reset = 1'b1;
      @(negedge clk);

      foreach (vecs[k]) run_frame(vecs[k]);

      // engine held not-ready: no start until it frees up, then a single pulse
      clear_logs();
      load_cfg(vecs[0]);
      ready_en = 1'b0;
      @(negedge clk);
      bus.start = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
      repeat (10) @(negedge clk);
      check("hold_no_start", 64'(nstart), 64'd0);
      check("hold_busy", 64'(bus.ready), 64'd0);
      ready_en = 1'b1;
      wait_start("hold_start_timeout", 1);
      @(negedge clk);
      check("hold_one_pulse", 64'(nstart), 64'd1);
      check("hold_pulse_low", 64'(bus.frac_start), 64'd0);
      wait_done("hold_done_timeout", 1);
      check("hold_writes", 64'(nwr), 64'd12);

      // abort during WAIT of pixel 2
      repeat (3) @(negedge clk);
      clear_logs();
      load_cfg(vecs[0]);
      eng_lat = 5;
      bus.start = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
      wait_start("abort_start_timeout", 3);
      bus.abort = 1'b1;
      @(negedge clk);
      bus.abort = 1'b0;
      wait_ready("abort_idle_timeout");
      check("abort_writes", 64'(nwr), 64'd3);
      if (nwr == 3) check("abort_last_addr", 64'(log_addr[2]), 64'd2);
      check("abort_ready", 64'(bus.ready), 64'd1);
      repeat (20) @(negedge clk);
      check("abort_no_done", 64'(ndone), 64'd0);
      check("abort_no_start", 64'(nstart), 64'd3);
      check("abort_no_write", 64'(nwr), 64'd3);

      // reset during WAIT of pixel 6, stray done afterwards, then restart
      clear_logs();
      load_cfg(vecs[0]);
      eng_lat = 6;
      bus.start = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
      wait_start("rst_start_timeout", 7);
      reset = 1'b0;
      @(negedge clk);
      reset = 1'b1;
      check_reset_state("midrst");
      check("midrst_writes", 64'(nwr), 64'd6);
      stray_req = 1'b1;
      repeat (10) @(negedge clk);
      check("stray_no_write", 64'(nwr), 64'd6);
      check("stray_no_start", 64'(nstart), 64'd7);
      check("stray_idle", 64'(bus.ready), 64'd1);
      run_frame(vecs[2]);

      // start held through a whole frame, then an immediate second frame
      clear_logs();
      load_cfg(vecs[0]);
      eng_lat = 2;
      bus.start = 1'b1;
      wait_done("held_done_timeout", 1);
      check("held_ready_at_done", 64'(bus.ready), 64'd1);
      check("held_starts", 64'(nstart), 64'd12);
      check("held_writes", 64'(nwr), 64'd12);
      @(negedge clk);
      check("held_restart", 64'(bus.ready), 64'd0);
      bus.start = 1'b0;
      wait_done("held_done2_timeout", 2);
      check("held_writes2", 64'(nwr), 64'd24);
      if (nwr == 24) check("held_addr_restart", 64'(log_addr[12]), 64'd0);

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
      $finish;
   end
endmodule
